// File: rtl/bitfusion_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitfusion_pkg
// Brief    : Shared widths, encodings and types for the bitfusion PE column.
// Revision : 1.0
// ============================================================================
package bitfusion_pkg;

    localparam logic [2:0] BW_2 = 3'b001;
    localparam logic [2:0] BW_4 = 3'b010;
    localparam logic [2:0] BW_8 = 3'b100;

    localparam int IN_W  = 32;
    localparam int ACC_W = 40;
    localparam int OUT_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic                    sat;
        logic signed [OUT_W-1:0] data;
    } psum_entry_t;

endpackage
`default_nettype wire

// File: rtl/psum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator_if
// Brief    : Beat input and result output handshakes of the psum accumulator.
// Revision : 1.0
// ============================================================================
interface psum_accumulator_if #(
    parameter int IN_W  = bitfusion_pkg::IN_W,
    parameter int OUT_W = bitfusion_pkg::OUT_W
);
    import bitfusion_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  shift_add_out;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;

    modport master (
        output in_valid, shift_add_out, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, shift_add_out, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface
`default_nettype wire

// File: rtl/psum_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : psum_out_fifo
// Brief    : Two-entry in-order register FIFO of completed partial sums.
// Revision : 1.0
// ============================================================================
module psum_out_fifo
    import bitfusion_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  nRST,
    input  wire logic  clear,
    input  wire logic  push,
    input  psum_entry_t push_entry,
    input  wire logic  pop,
    output psum_entry_t head,
    output logic       full,
    output logic       empty
);

    psum_entry_t r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Brief    : Groups shift_add beats into saturated partial sums, buffered out.
// Revision : 1.0
// ============================================================================
module psum_accumulator #(
    parameter int IN_W  = bitfusion_pkg::IN_W,
    parameter int ACC_W = bitfusion_pkg::ACC_W,
    parameter int OUT_W = bitfusion_pkg::OUT_W,
    parameter int LEN_W = 16
) (
    input  wire logic             clk,
    input  wire logic             nRST,
    input  wire logic             clear,
    input  wire logic [LEN_W-1:0] cfg_len,
    output logic                  group_active,
    psum_accumulator_if.slave     bus
);
    import bitfusion_pkg::*;

    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    acc_state_t               r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [LEN_W-1:0]         r_count;
    logic [LEN_W-1:0]         r_len_q;
    logic                     r_group_active;

    logic                     w_full;
    logic                     w_empty;
    psum_entry_t              w_head;
    psum_entry_t              w_push_entry;
    logic                     w_beat;
    logic                     w_last;
    logic                     w_push;
    logic [LEN_W-1:0]         w_len_eff;
    logic signed [ACC_W-1:0]  w_in_ext;
    logic signed [ACC_W-1:0]  w_sum;

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head.data;
    assign bus.out_sat   = w_head.sat;
    assign group_active  = r_group_active;

    assign w_beat    = bus.in_valid && !w_full && !clear;
    assign w_len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign w_in_ext  = {{(ACC_W-IN_W){bus.shift_add_out[IN_W-1]}}, bus.shift_add_out};
    // r_acc is zero whenever the FSM is in IDLE, so one adder serves both states.
    assign w_sum     = r_acc + w_in_ext;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            IDLE:    w_last = (w_len_eff == LEN_W'(1));
            ACCUM:   w_last = ((r_count + LEN_W'(1)) == r_len_q);
            default: w_last = 1'b0;
        endcase
    end

    assign w_push = w_beat && w_last;

    always_comb begin
        w_push_entry = '0;
        if (w_sum > c_sat_max) begin
            w_push_entry.sat  = 1'b1;
            w_push_entry.data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_sum < c_sat_min) begin
            w_push_entry.sat  = 1'b1;
            w_push_entry.data = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            w_push_entry.sat  = 1'b0;
            w_push_entry.data = w_sum[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_len_q        <= '0;
            r_group_active <= 1'b0;
        end else if (clear) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_group_active <= 1'b0;
        end else if (w_beat) begin
            case (r_state)
                IDLE: begin
                    r_len_q <= w_len_eff;
                    if (!w_last) begin
                        r_acc          <= w_sum;
                        r_count        <= LEN_W'(1);
                        r_state        <= ACCUM;
                        r_group_active <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_last) begin
                        r_acc          <= '0;
                        r_count        <= '0;
                        r_state        <= IDLE;
                        r_group_active <= 1'b0;
                    end else begin
                        r_acc   <= w_sum;
                        r_count <= r_count + LEN_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    psum_out_fifo u_fifo (
        .clk        (clk),
        .nRST       (nRST),
        .clear      (clear),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (bus.out_ready),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty)
    );

endmodule
`default_nettype wire
